// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared defines: RV32M funct3 codes, FSM states,
// operand signedness classes and small decode helpers.
package muldiv_unit_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] INST_MUL    = 3'b000;
   localparam logic [2:0] INST_MULH   = 3'b001;
   localparam logic [2:0] INST_MULHSU = 3'b010;
   localparam logic [2:0] INST_MULHU  = 3'b011;
   localparam logic [2:0] INST_DIV    = 3'b100;
   localparam logic [2:0] INST_DIVU   = 3'b101;
   localparam logic [2:0] INST_REM    = 3'b110;
   localparam logic [2:0] INST_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CLS_SS = 2'd0,
      CLS_SU = 2'd1,
      CLS_UU = 2'd2
   } sign_cls_e;

   function automatic sign_cls_e op_class(input logic [2:0] f);
      sign_cls_e c;
      case (f)
         INST_MULHSU: c = CLS_SU;
         INST_MULHU,
         INST_DIVU,
         INST_REMU:   c = CLS_UU;
         default:     c = CLS_SS;
      endcase
      return c;
   endfunction

   function automatic logic is_mul_op(input logic [2:0] f);
      return (f == INST_MUL) || (f == INST_MULH) ||
             (f == INST_MULHSU) || (f == INST_MULHU);
   endfunction

   // Ops whose result lives in the upper half of {rem,quo} / product.
   function automatic logic sel_high(input logic [2:0] f);
      return (f != INST_MUL) && (f != INST_DIV) && (f != INST_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit request/response bundle: pipeline side is master,
// the unit is slave.
interface muldiv_unit_if #(
   parameter int XLEN = muldiv_unit_pkg::XLEN_DEFAULT
);
   logic            req_in;
   logic [2:0]      funct3_in;
   logic [XLEN-1:0] op1_in;
   logic [XLEN-1:0] op2_in;
   logic [4:0]      rd_in;
   logic            kill_in;
   logic            busy_out;
   logic            valid_out;
   logic [XLEN-1:0] result_out;
   logic [4:0]      rd_out;

   modport master (
      output req_in, funct3_in, op1_in, op2_in, rd_in, kill_in,
      input  busy_out, valid_out, result_out, rd_out
   );

   modport slave (
      input  req_in, funct3_in, op1_in, op2_in, rd_in, kill_in,
      output busy_out, valid_out, result_out, rd_out
   );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per
// cycle; done is high during the cycle that retires the last bit.
module muldiv_div_core
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   logic            run_q, run_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dsr_q, dsr_d;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic            ge;

   assign shifted   = {rem_q, quo_q[XLEN-1]};
   assign diff      = shifted - {1'b0, dsr_q};
   assign ge        = ~diff[XLEN];
   assign done      = run_q && (cnt_q == LAST);
   assign quotient  = quo_q;
   assign remainder = rem_q;

   // Load on start, then trial-subtract one bit per cycle.
   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dsr_d = dsr_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         quo_d = dividend;
         rem_d = '0;
         dsr_d = divisor;
      end else if (run_q) begin
         rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
         quo_d = {quo_q[XLEN-2:0], ge};
         cnt_d = cnt_q + CW'(1);
         if (done) begin
            run_d = 1'b0;
         end
      end
      if (abort) begin
         run_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dsr_q <= dsr_d;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiplier,
// restoring divider, special-case fast path and last-result cache.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int MUL_BITS = 4,
   parameter int CACHE_EN = 1
) (
   input  logic         clk_in,
   input  logic         reset_in,
   muldiv_unit_if.slave bus
);

   localparam int NSTEP = XLEN / MUL_BITS;
   localparam int PW    = 2 * XLEN;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [4:0]      rd_q, rd_d;
   logic [4:0]      tag_q, tag_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   sign_cls_e       cls_q, cls_d;
   logic            fast_q, fast_d;
   logic            flip_q, flip_d;
   logic            rflip_q, rflip_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] mcand_q, mcand_d;

   logic            cv_q, cv_d;
   logic            cmul_q, cmul_d;
   sign_cls_e       ccls_q, ccls_d;
   logic [XLEN-1:0] ca_q, ca_d;
   logic [XLEN-1:0] cb_q, cb_d;
   logic [PW-1:0]   cdata_q, cdata_d;

   logic            accept;
   logic            in_mul;
   sign_cls_e       in_cls;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, ovf, hit, fast;
   logic [PW-1:0]   fast_val;
   logic [XLEN+MUL_BITS-1:0] pp;
   logic [PW-1:0]   mul_next;
   logic [PW-1:0]   fin_res;
   logic            div_start, div_done;
   logic [XLEN-1:0] div_quo, div_rem;
   logic            valid_o;

   assign accept = bus.req_in && !bus.kill_in && (state_q == ST_IDLE);
   assign in_mul = is_mul_op(bus.funct3_in);
   assign in_cls = op_class(bus.funct3_in);
   assign a_neg  = (in_cls != CLS_UU) && bus.op1_in[XLEN-1];
   assign b_neg  = (in_cls == CLS_SS) && bus.op2_in[XLEN-1];
   assign a_mag  = a_neg ? -bus.op1_in : bus.op1_in;
   assign b_mag  = b_neg ? -bus.op2_in : bus.op2_in;

   assign div_zero = !in_mul && (bus.op2_in == '0);
   assign ovf      = !in_mul && (in_cls == CLS_SS) &&
                     (bus.op1_in == MIN_NEG) && (bus.op2_in == '1);

   // A MUL only needs the low half, which any signedness agrees on.
   assign hit = (CACHE_EN != 0) && cv_q && (cmul_q == in_mul) &&
                (ca_q == bus.op1_in) && (cb_q == bus.op2_in) &&
                ((ccls_q == in_cls) || (bus.funct3_in == INST_MUL));

   assign fast      = hit || div_zero || ovf;
   assign div_start = accept && !in_mul && !fast;

   // Fast-path result laid out as {hi/rem, lo/quo}.
   always_comb begin
      if (hit) begin
         fast_val = cdata_q;
      end else if (div_zero) begin
         fast_val = {bus.op1_in, {XLEN{1'b1}}};
      end else begin
         fast_val = {{XLEN{1'b0}}, bus.op1_in};
      end
   end

   // One radix-2^MUL_BITS step: add shifted multiplicand copies.
   always_comb begin
      pp = {{MUL_BITS{1'b0}}, acc_q[PW-1:XLEN]};
      for (int i = 0; i < MUL_BITS; i++) begin
         if (acc_q[i]) begin
            pp = pp + ({{MUL_BITS{1'b0}}, mcand_q} << i);
         end
      end
      mul_next = PW'({pp, acc_q[XLEN-1:0]} >> MUL_BITS);
   end

   // Sign fix-up of the raw magnitude result.
   always_comb begin
      if (fast_q) begin
         fin_res = acc_q;
      end else if (is_mul_op(op_q)) begin
         fin_res = flip_q ? -acc_q : acc_q;
      end else begin
         fin_res = {rflip_q ? -div_rem : div_rem,
                    flip_q  ? -div_quo : div_quo};
      end
   end

   muldiv_div_core #(
      .XLEN (XLEN)
   ) u_div (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .start     (div_start),
      .abort     (bus.kill_in),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // FSM next state, datapath and cache update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      res_d   = '0;
      rd_d    = '0;
      tag_d   = tag_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cls_d   = cls_q;
      fast_d  = fast_q;
      flip_d  = flip_q;
      rflip_d = rflip_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cv_d    = cv_q;
      cmul_d  = cmul_q;
      ccls_d  = ccls_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      cdata_d = cdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tag_d   = bus.rd_in;
               op_d    = bus.funct3_in;
               a_d     = bus.op1_in;
               b_d     = bus.op2_in;
               cls_d   = hit ? ccls_q : in_cls;
               flip_d  = a_neg ^ b_neg;
               rflip_d = a_neg;
               cnt_d   = '0;
               fast_d  = fast;
               if (fast) begin
                  acc_d   = fast_val;
                  state_d = ST_FIX;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  mcand_d = a_mag;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (is_mul_op(op_q)) begin
               acc_d = mul_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = ST_FIX;
               end
            end else if (div_done) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            res_d   = sel_high(op_q) ? fin_res[PW-1:XLEN]
                                     : fin_res[XLEN-1:0];
            rd_d    = tag_q;
            if (CACHE_EN != 0) begin
               cv_d    = 1'b1;
               cmul_d  = is_mul_op(op_q);
               ccls_d  = cls_q;
               ca_d    = a_q;
               cb_d    = b_q;
               cdata_d = fin_res;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (bus.kill_in) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         res_d   = '0;
         rd_d    = '0;
         cnt_d   = '0;
         if (state_q != ST_IDLE) begin
            cv_d = 1'b0;
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   // All unit state; reset wins over kill and request.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         res_q   <= '0;
         rd_q    <= '0;
         tag_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cls_q   <= CLS_SS;
         fast_q  <= 1'b0;
         flip_q  <= 1'b0;
         rflip_q <= 1'b0;
         acc_q   <= '0;
         mcand_q <= '0;
         cv_q    <= 1'b0;
         cmul_q  <= 1'b0;
         ccls_q  <= CLS_SS;
         ca_q    <= '0;
         cb_q    <= '0;
         cdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         tag_q   <= tag_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cls_q   <= cls_d;
         fast_q  <= fast_d;
         flip_q  <= flip_d;
         rflip_q <= rflip_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cv_q    <= cv_d;
         cmul_q  <= cmul_d;
         ccls_q  <= ccls_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         cdata_q <= cdata_d;
      end
   end

   // A kill in the DONE cycle still swallows the pulse.
   assign valid_o        = valid_q && !bus.kill_in;
   assign bus.valid_out  = valid_o;
   assign bus.busy_out   = busy_q;
   assign bus.result_out = valid_o ? res_q : '0;
   assign bus.rd_out     = valid_o ? rd_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases then random ops,
// checked against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int XLEN     = 32;
   localparam int MUL_BITS = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   bit          m_cv;
   bit          m_mul;
   bit [1:0]    m_sg;
   logic [31:0] m_a, m_b;

   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(XLEN)) bus();

   muldiv_unit #(
      .XLEN     (XLEN),
      .MUL_BITS (MUL_BITS),
      .CACHE_EN (1)
   ) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .bus      (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic bit a_sgn(input logic [2:0] f);
      return f inside {INST_MUL, INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
   endfunction

   function automatic bit b_sgn(input logic [2:0] f);
      return f inside {INST_MUL, INST_MULH, INST_DIV, INST_REM};
   endfunction

   function automatic logic [31:0] ref_res(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] ea, eb, p;
      logic [31:0] q, r;
      int ia, ib;
      ea = a_sgn(f) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = b_sgn(f) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      ia = a;
      ib = b;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (a_sgn(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 0;
      end else if (a_sgn(f)) begin
         q = ia / ib; r = ia % ib;
      end else begin
         q = a / b; r = a % b;
      end
      case (f)
         INST_MUL:                          return p[31:0];
         INST_MULH, INST_MULHSU, INST_MULHU: return p[63:32];
         INST_DIV, INST_DIVU:               return q;
         default:                           return r;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input bit poke, input string nm);
      bit is_mul, sa, sb, hit, busy_ok, quiet_ok;
      int lat, exp_lat;
      logic [31:0] exp_res;
      is_mul = f inside {INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU};
      sa = a_sgn(f);
      sb = b_sgn(f);
      hit = m_cv && (m_mul == is_mul) && m_a == a && m_b == b &&
            ({sa, sb} == m_sg || f == INST_MUL);
      if (hit) exp_lat = 2;
      else if (!is_mul && (b == 0 || (sa && a == 32'h8000_0000 &&
               b == 32'hFFFF_FFFF))) exp_lat = 2;
      else if (is_mul) exp_lat = XLEN / MUL_BITS + 2;
      else exp_lat = XLEN + 2;
      exp_res = ref_res(f, a, b);
      busy_ok = 1; quiet_ok = 1; lat = 0;
      @(negedge clk);
      bus.req_in = 1'b1; bus.funct3_in = f;
      bus.op1_in = a; bus.op2_in = b; bus.rd_in = tag;
      @(negedge clk);
      if (poke) begin
         bus.funct3_in = INST_MULHU; bus.op1_in = ~a;
         bus.op2_in = a ^ b; bus.rd_in = ~tag;
      end else begin
         bus.req_in = 1'b0;
      end
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 4) bus.req_in = 1'b0;
         if (bus.busy_out !== 1'b1) busy_ok = 0;
         if (bus.valid_out === 1'b1) begin
            lat = k;
            break;
         end
         if (bus.result_out !== '0 || bus.rd_out !== '0) quiet_ok = 0;
      end
      bus.req_in = 1'b0;
      check({nm, ".lat"}, lat, exp_lat);
      check({nm, ".res"}, bus.result_out, exp_res);
      check({nm, ".rd"}, bus.rd_out, tag);
      check({nm, ".busy"}, busy_ok, 1);
      check({nm, ".quiet"}, quiet_ok, 1);
      @(negedge clk);
      check({nm, ".pulse"}, {bus.valid_out, bus.busy_out}, 0);
      if (lat != 0 && !hit) begin
         m_cv = 1; m_mul = is_mul; m_sg = {sa, sb}; m_a = a; m_b = b;
      end
   endtask

   initial begin
      logic [31:0] pa, pb, ra, rb;
      int mode;
      logic [2:0] rf;
      rst = 1'b1;
      bus.req_in = 0; bus.funct3_in = 0; bus.op1_in = 0;
      bus.op2_in = 0; bus.rd_in = 0; bus.kill_in = 0;
      m_cv = 0; m_mul = 0; m_sg = 0; m_a = 0; m_b = 0;
      repeat (3) @(negedge clk);
      check("rst.valid", bus.valid_out, 0);
      check("rst.busy", bus.busy_out, 0);
      check("rst.res", bus.result_out, 0);
      check("rst.rd", bus.rd_out, 0);
      rst = 1'b0;

      run_op(INST_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, "mulh_m1");
      run_op(INST_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "mul_hit");
      run_op(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, "div_m7");
      run_op(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, "rem_hit");
      run_op(INST_DIVU, 32'h1234_5678, 32'd0, 5'd5, 0, "divu_z");
      run_op(INST_REMU, 32'h1234_5678, 32'd0, 5'd6, 0, "remu_z");
      run_op(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, "div_ovf");
      run_op(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, "rem_ovf");

      @(negedge clk);
      bus.req_in = 1'b1; bus.funct3_in = INST_MULHSU;
      bus.op1_in = 32'hFFFF_FFFF; bus.op2_in = 32'hFFFF_FFFF;
      bus.rd_in = 5'd9;
      @(negedge clk);
      bus.req_in = 1'b0;
      repeat (4) @(negedge clk);
      bus.kill_in = 1'b1;
      #1;
      check("kill.now", bus.valid_out, 0);
      @(negedge clk);
      bus.kill_in = 1'b0;
      #1;
      check("kill.after", {bus.busy_out, bus.valid_out}, 0);
      m_cv = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.valid_out !== 1'b0) check("kill.late", bus.valid_out, 0);
      end
      run_op(INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, "mulhsu");

      @(negedge clk);
      bus.req_in = 1'b1; bus.kill_in = 1'b1; bus.funct3_in = INST_MUL;
      bus.op1_in = 32'd3; bus.op2_in = 32'd4;
      @(negedge clk);
      bus.req_in = 1'b0; bus.kill_in = 1'b0;
      #1;
      check("killreq.busy", bus.busy_out, 0);

      run_op(INST_DIVU, 32'd1000, 32'd7, 5'd5, 1, "poke");

      @(negedge clk);
      bus.req_in = 1'b1; bus.funct3_in = INST_DIV;
      bus.op1_in = 32'd12345; bus.op2_in = 32'd17; bus.rd_in = 5'd11;
      @(negedge clk);
      bus.req_in = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1; bus.kill_in = 1'b1; bus.req_in = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.kill_in = 1'b0; bus.req_in = 1'b0;
      #1;
      check("midrst.out", {bus.busy_out, bus.valid_out,
                           bus.rd_out, bus.result_out}, 0);
      m_cv = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.valid_out !== 1'b0) check("midrst.late", bus.valid_out, 0);
      end
      run_op(INST_MUL, 32'd3, 32'd5, 5'd12, 0, "after_rst");

      pa = 32'd3; pb = 32'd5;
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         mode = $urandom_range(0, 9);
         case (mode)
            0: begin ra = pa; rb = pb; end
            1: begin ra = $urandom; rb = 32'd0; end
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: begin ra = $urandom_range(0, 20);
                     rb = $urandom_range(1, 9); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         run_op(rf, ra, rb, 5'($urandom_range(0, 31)), 0, "rnd");
         pa = ra; pb = rb;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter MUL_BITS, default 4, multiplier bits retired per cycle (must divide XLEN).
REQ-003 SHALL have parameter CACHE_EN, default 1, enables the last-result reuse cache.
REQ-004 SHALL have port clk_in  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_in  input  1  request; accepted only when busy_out=0.
REQ-007 SHALL have port funct3_in  input  3  RV32M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports op1_in, op2_in  input  XLEN each  rs1/rs2 values, sampled at acceptance.
REQ-009 SHALL have port rd_in  input  5  destination tag, sampled at acceptance.
REQ-010 SHALL have port kill_in  input  1  pipeline flush; aborts any in-flight op.
REQ-011 SHALL have port busy_out  output  1  high from cycle after acceptance until valid_out cycle inclusive.
REQ-012 SHALL have ports valid_out  output  1 / result_out  output  XLEN / rd_out  output  5  one-cycle result pulse with tag.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on accepted normal op, IDLE->FIX on fast-path op, CALC->FIX when step counter expires, FIX->DONE, DONE->IDLE.
REQ-014 Multiplier SHALL be iterative shift-add on operand magnitudes, MUL_BITS per cycle, XLEN/MUL_BITS CALC cycles, full 2*XLEN product.
REQ-015 Divider SHALL be restoring, 1 quotient bit per cycle, XLEN CALC cycles, on operand magnitudes.
REQ-016 Signedness: MUL/MULH/DIV/REM both signed; MULHSU op1 signed only; MULHU/DIVU/REMU unsigned.
REQ-017 FIX SHALL negate product when operand signs differ (signed-treated operands), negate quotient when dividend/divisor signs differ, remainder takes dividend sign.
REQ-018 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-019 Divide by zero (fast path): quotient all-ones, remainder = op1_in, no CALC.
REQ-020 Signed overflow DIV/REM of most-negative by -1 (fast path): quotient = op1_in, remainder 0.
REQ-021 valid_out SHALL be high exactly in DONE; latency acceptance->valid_out = XLEN/MUL_BITS+2 cycles (mul), XLEN+2 (div), 2 (fast path or cache hit).
REQ-022 result_out and rd_out SHALL be zero whenever valid_out=0.
REQ-023 Cache (CACHE_EN=1): after each completed op store operands, signedness class, full product or quotient+remainder; a new op hits when same unit, equal operands, and equal signedness class (MUL hits any mul class).
REQ-024 kill_in high in any cycle SHALL force IDLE next cycle, suppress valid_out that cycle and onward, and invalidate the cache entry being built; kill_in with req_in in IDLE SHALL not accept.
REQ-025 req_in while busy_out=1 SHALL be ignored (no queueing); new request SHALL be accepted in the cycle after DONE.
REQ-026 Invalid funct3 impossible by encoding; all eight codes SHALL be supported.

Reset
REQ-027 reset_in SHALL set state IDLE, busy_out 0, valid_out 0, result_out 0, rd_out 0, step counter 0, cache invalid.
REQ-028 reset_in SHALL take priority over kill_in and req_in, including mid-CALC.

Structure
REQ-029 Funct3 codes, FSM state encoding and XLEN default SHALL live in the shared defines package, alongside existing INST_MUL..INST_REMU.
REQ-030 Divider datapath SHALL be sub-module muldiv_div_core (start, done, quotient, remainder); multiplier datapath stays inline.

Verification
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> result 0x00000000 after 10 cycles; then MUL same operands -> 0x00000001 after 2 cycles (cache hit).
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD after 34 cycles; REM same operands -> 0xFFFFFFFF after 2 cycles.
REQ-033 DIVU 0x12345678 / 0 -> 0xFFFFFFFF, REMU -> 0x12345678, each 2 cycles.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; 2 cycles.
REQ-035 MULHSU 0xFFFFFFFF x 0xFFFFFFFF with kill_in at cycle 5 -> no valid_out, busy_out 0 next cycle, following MULHSU -> 0xFFFFFFFF after full 10 cycles (no cache hit).
REQ-036 reset_in asserted mid-DIV CALC -> all outputs 0 next cycle; req_in during busy -> ignored, rd_out carries original tag.
